// File: rtl/eth_tx_framer_pkg.sv
// Shared types, framing constants and the byte-wise CRC-32 step for the TX framer.
package eth_tx_framer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StPayload,
        StPad,
        StFcs,
        StIfg
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE          = 8'hD5;
    localparam int unsigned PREAMBLE_LEN      = 7;
    localparam int unsigned FCS_LEN           = 4;
    localparam int unsigned DEFAULT_MIN_LEN   = 60;
    localparam int unsigned DEFAULT_IFG_BYTES = 12;

    // Reflected IEEE 802.3 polynomial.
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ data[i]}});
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// FIFO-drain and byte-stream signals between the framer and its neighbours.
interface eth_tx_framer_if;

    logic       i_fifo_empty;
    logic [7:0] i_fifo_data;
    logic       o_fifo_rd;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_data,
        input  i_tx_ready,
        output o_fifo_rd,
        output o_tx_data,
        output o_tx_valid
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_data,
        output i_tx_ready,
        input  o_fifo_rd,
        input  o_tx_data,
        input  o_tx_valid
    );

endinterface

// File: rtl/eth_tx_framer_crc32.sv
// IEEE 802.3 CRC-32, one byte per enabled cycle; output is already complemented.
module eth_tx_framer_crc32
    import eth_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = crc32_byte(state_q, data_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 32'hFFFF_FFFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign crc = ~state_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Drains a payload from the TX FIFO and emits preamble, SFD, payload, pad, FCS and IFG.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int unsigned MIN_LEN   = DEFAULT_MIN_LEN,
    parameter int unsigned IFG_BYTES = DEFAULT_IFG_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [10:0]            i_len,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_underrun,
    eth_tx_framer_if.master        tx_bus
);

    localparam logic [10:0] MinLen  = 11'(MIN_LEN);
    localparam logic [10:0] PreLast = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] FcsLen  = 11'(FCS_LEN);
    localparam logic [10:0] IfgLast = (IFG_BYTES == 0) ? 11'd0 : 11'(IFG_BYTES - 1);

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [10:0] target_q, target_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;

    logic        can_load;
    logic [10:0] cnt_next;
    logic        fifo_rd;
    logic        crc_clear;
    logic        crc_en;
    logic [31:0] crc;
    logic [7:0]  fcs_byte;

    eth_tx_framer_crc32 u_crc32 (
        .clk     (clk),
        .rst     (rst | crc_clear),
        .en      (crc_en),
        .data_in (tx_data_d),
        .crc     (crc)
    );

    // FCS goes out least-significant byte first.
    always_comb begin
        case (cnt_q[1:0])
            2'd0:    fcs_byte = crc[7:0];
            2'd1:    fcs_byte = crc[15:8];
            2'd2:    fcs_byte = crc[23:16];
            default: fcs_byte = crc[31:24];
        endcase
    end

    // The output register may take a new byte when empty or being accepted this edge.
    assign can_load = !tx_valid_q || tx_bus.i_tx_ready;
    assign cnt_next = cnt_q + 11'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        target_d   = target_q;
        underrun_d = underrun_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        fifo_rd    = 1'b0;
        crc_clear  = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            StIdle: begin
                tx_valid_d = 1'b0;
                if (i_start) begin
                    len_d      = i_len;
                    target_d   = (i_len > MinLen) ? i_len : MinLen;
                    underrun_d = 1'b0;
                    crc_clear  = 1'b1;
                    cnt_d      = '0;
                    state_d    = StPreamble;
                end
            end
            StPreamble: begin
                if (can_load) begin
                    tx_data_d  = PREAMBLE_BYTE;
                    tx_valid_d = 1'b1;
                    if (cnt_q == PreLast) begin
                        cnt_d   = '0;
                        state_d = StSfd;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            StSfd: begin
                if (can_load) begin
                    tx_data_d  = SFD_BYTE;
                    tx_valid_d = 1'b1;
                    cnt_d      = '0;
                    if (len_q != '0) begin
                        state_d = StPayload;
                    end else if (target_q != '0) begin
                        state_d = StPad;
                    end else begin
                        state_d = StFcs;
                    end
                end
            end
            StPayload: begin
                if (can_load) begin
                    if (!tx_bus.i_fifo_empty) begin
                        tx_data_d  = tx_bus.i_fifo_data;
                        tx_valid_d = 1'b1;
                        fifo_rd    = 1'b1;
                        crc_en     = 1'b1;
                        if (cnt_next == len_q) begin
                            if (len_q == target_q) begin
                                cnt_d   = '0;
                                state_d = StFcs;
                            end else begin
                                cnt_d   = cnt_next;
                                state_d = StPad;
                            end
                        end else begin
                            cnt_d = cnt_next;
                        end
                    end else begin
                        // Starved: emit a bubble and wait for the FIFO rather than abort.
                        tx_valid_d = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
            StPad: begin
                if (can_load) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b1;
                    crc_en     = 1'b1;
                    if (cnt_next == target_q) begin
                        cnt_d   = '0;
                        state_d = StFcs;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            StFcs: begin
                if (can_load) begin
                    if (cnt_q == FcsLen) begin
                        // Last FCS byte has just been accepted.
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        cnt_d      = '0;
                        state_d    = (IFG_BYTES == 0) ? StIdle : StIfg;
                    end else begin
                        tx_data_d  = fcs_byte;
                        tx_valid_d = 1'b1;
                        cnt_d      = cnt_next;
                    end
                end
            end
            StIfg: begin
                tx_valid_d = 1'b0;
                if (cnt_q == IfgLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            target_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            target_q   <= target_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_underrun       = underrun_q;
    assign tx_bus.o_fifo_rd  = fifo_rd & ~rst;
    assign tx_bus.o_tx_data  = tx_data_q;
    assign tx_bus.o_tx_valid = tx_valid_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench: table of frame vectors plus hand-written reset and reset-mid-frame sequences.
module tb_eth_tx_framer;

    localparam int IFG = 12;
    localparam int GAP = 10;

    typedef struct {
        logic sel;        // 0: default DUT, 1: MIN_LEN=9 DUT
        int   len;
        int   dmode;      // 0: "123456789", 1: AA BB CC.., 2: pattern
        logic rnd;        // random ready
        int   gap_after;  // hold FIFO empty after this many pops (0: never)
        logic spur;       // spurious starts in PAYLOAD and IFG
        logic exp_und;
        logic cmp_prev;   // stream must equal previous vector's stream
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, sel, rdy, rnd_ready;
    logic [10:0] len;
    logic        fifo_empty_r;
    logic [7:0]  fifo_data_r;

    logic        busy_a, done_a, und_a, busy_b, done_b, und_b;
    logic        obs_busy, obs_done, obs_und, obs_rd, obs_valid;
    logic [7:0]  obs_data;

    eth_tx_framer_if bus_a ();
    eth_tx_framer_if bus_b ();

    assign bus_a.i_fifo_empty = sel ? 1'b1 : fifo_empty_r;
    assign bus_b.i_fifo_empty = sel ? fifo_empty_r : 1'b1;
    assign bus_a.i_fifo_data  = fifo_data_r;
    assign bus_b.i_fifo_data  = fifo_data_r;
    assign bus_a.i_tx_ready   = rdy;
    assign bus_b.i_tx_ready   = rdy;

    eth_tx_framer dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start & ~sel),
        .i_len      (len),
        .o_busy     (busy_a),
        .o_done     (done_a),
        .o_underrun (und_a),
        .tx_bus     (bus_a)
    );

    eth_tx_framer #(.MIN_LEN(9)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start & sel),
        .i_len      (len),
        .o_busy     (busy_b),
        .o_done     (done_b),
        .o_underrun (und_b),
        .tx_bus     (bus_b)
    );

    assign obs_busy  = sel ? busy_b : busy_a;
    assign obs_done  = sel ? done_b : done_a;
    assign obs_und   = sel ? und_b  : und_a;
    assign obs_rd    = sel ? bus_b.o_fifo_rd  : bus_a.o_fifo_rd;
    assign obs_valid = sel ? bus_b.o_tx_valid : bus_a.o_tx_valid;
    assign obs_data  = sel ? bus_b.o_tx_data  : bus_a.o_tx_data;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q[$];
    logic [7:0] rx[$];
    logic [7:0] prev_rx[$];
    logic [7:0] expq[$];
    int pops, bad_pop, hold_cnt, stall_viol, gap_viol, done_cnt;
    int tick_no, done_tick, busy_low_tick;
    logic prev_stall;
    logic [7:0] prev_data;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty_r = (q.size() == 0) || (hold_cnt > 0);
        fifo_data_r  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    // Observe before the edge, then apply FIFO pops and stream captures just after it.
    task automatic tick();
        logic       acc, rd;
        logic [7:0] d;
        @(negedge clk);
        acc = obs_valid && rdy;
        rd  = obs_rd;
        d   = obs_data;
        if (obs_done) begin
            done_cnt++;
            done_tick = tick_no;
        end
        if (!obs_busy && done_tick >= 0 && busy_low_tick < 0) busy_low_tick = tick_no;
        if (prev_stall && (!obs_valid || obs_data !== prev_data)) stall_viol++;
        prev_stall = obs_valid && !rdy;
        prev_data  = obs_data;
        if (hold_cnt > 0 && hold_cnt < GAP && obs_valid) gap_viol++;
        @(posedge clk);
        #1;
        tick_no++;
        if (rd) begin
            if (q.size() == 0) bad_pop++;
            else void'(q.pop_front());
            pops++;
        end
        if (acc) rx.push_back(d);
        if (hold_cnt > 0) hold_cnt--;
        rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        refresh();
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] b[$], input int from);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < b.size(); i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        return (i >= 0 && i < rx.size()) ? rx[i] : 8'h00;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0]  pl[$];
        logic [31:0] fcs;
        int          minlen, total, mism;
        logic        spur1, spur2, gap_done;
        pl = {};
        for (int i = 0; i < v.len; i++) begin
            case (v.dmode)
                0:       pl.push_back(8'h31 + 8'(i));
                1:       pl.push_back(8'hAA + 8'(8'h11 * i));
                default: pl.push_back(8'((i * 37 + 5) & 255));
            endcase
        end
        minlen = v.sel ? 9 : 60;
        total  = (v.len > minlen) ? v.len : minlen;
        expq = {};
        for (int i = 0; i < 7; i++) expq.push_back(8'h55);
        expq.push_back(8'hD5);
        foreach (pl[i]) expq.push_back(pl[i]);
        for (int i = v.len; i < total; i++) expq.push_back(8'h00);
        fcs = ref_crc(expq, 8);
        for (int i = 0; i < 4; i++) expq.push_back(fcs[8*i +: 8]);

        q = pl;
        for (int i = 0; i < 4; i++) q.push_back(8'hEE);
        rx = {};
        pops = 0; bad_pop = 0; hold_cnt = 0; stall_viol = 0; gap_viol = 0; done_cnt = 0;
        done_tick = -1; busy_low_tick = -1; prev_stall = 1'b0;
        spur1 = 1'b0; spur2 = 1'b0; gap_done = 1'b0;
        sel = v.sel; rnd_ready = v.rnd; rdy = 1'b1;
        refresh();

        start = 1'b1;
        len = 11'(v.len);
        tick();
        start = 1'b0;
        check({tag, "_start_busy"}, {30'd0, obs_busy, obs_valid}, 32'd2);
        tick();
        check({tag, "_first_byte"}, {23'd0, obs_valid, obs_data}, 32'h155);

        for (int c = 0; c < 4000 && !(done_cnt > 0 && busy_low_tick >= 0); c++) begin
            if (v.spur && !spur1 && pops == 3) begin
                start = 1'b1; len = 11'd5; spur1 = 1'b1;
            end else if (v.spur && !spur2 && done_cnt > 0) begin
                start = 1'b1; len = 11'd5; spur2 = 1'b1;
            end
            tick();
            start = 1'b0;
            if (v.gap_after > 0 && !gap_done && pops == v.gap_after) begin
                hold_cnt = GAP; gap_done = 1'b1; refresh();
            end
        end
        check({tag, "_terminated"}, 32'(done_cnt > 0 && busy_low_tick >= 0), 32'd1);

        mism = 0;
        for (int i = 0; i < expq.size(); i++) if (rx_at(i) !== expq[i]) mism++;
        check({tag, "_stream_len"}, 32'(rx.size()), 32'(expq.size()));
        check({tag, "_stream_mismatches"}, 32'(mism), 32'd0);
        check({tag, "_pops"}, 32'(pops), 32'(v.len));
        check({tag, "_pop_when_empty"}, 32'(bad_pop), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_ifg_cycles"}, 32'(busy_low_tick - done_tick), 32'(IFG));
        check({tag, "_stall_stable"}, 32'(stall_viol), 32'd0);
        check({tag, "_underrun"}, {31'd0, obs_und}, {31'd0, v.exp_und});
        if (v.gap_after > 0) check({tag, "_gap_valid_low"}, 32'(gap_viol), 32'd0);
        if (v.dmode == 0) begin
            check({tag, "_fcs_literal"},
                  {rx_at(rx.size() - 1), rx_at(rx.size() - 2), rx_at(rx.size() - 3),
                   rx_at(rx.size() - 4)}, 32'hCBF4_3926);
        end
        if (v.cmp_prev) begin
            mism = (rx.size() == prev_rx.size()) ? 0 : 1;
            foreach (rx[i]) if (i < prev_rx.size() && rx[i] !== prev_rx[i]) mism++;
            check({tag, "_same_as_ready_high"}, 32'(mism), 32'd0);
        end
        prev_rx = rx;
    endtask

    initial begin
        //          sel   len dm rnd  gap spur  und  cmp
        vecs[0]  = '{1'b1,  9, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0,  3, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 64, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 64, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 20, 2, 1'b0, 5, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 20, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0,  0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 60, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1,  0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 10, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 30, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; len = '0; sel = 1'b0; rdy = 1'b1; rnd_ready = 1'b0;
        hold_cnt = 0; tick_no = 0; q = {};
        refresh();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_done", {31'd0, done_a}, 32'd0);
        check("reset_underrun", {31'd0, und_a}, 32'd0);
        check("reset_fifo_rd", {31'd0, bus_a.o_fifo_rd}, 32'd0);
        check("reset_valid", {31'd0, bus_a.o_tx_valid}, 32'd0);
        check("reset_data", {24'd0, bus_a.o_tx_data}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a payload, then a clean frame.
        sel = 1'b0; rnd_ready = 1'b0; rdy = 1'b1; hold_cnt = 0; pops = 0; bad_pop = 0;
        done_tick = -1; busy_low_tick = -1; prev_stall = 1'b0;
        q = {};
        for (int i = 0; i < 40; i++) q.push_back(8'(i + 1));
        refresh();
        start = 1'b1; len = 11'd30;
        tick();
        start = 1'b0;
        for (int c = 0; c < 500 && pops < 10; c++) tick();
        check("rst_mid_reached_payload", 32'(pops), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_no_pop", {31'd0, obs_rd}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, obs_busy}, 32'd0);
        check("rst_mid_valid", {31'd0, obs_valid}, 32'd0);
        @(negedge clk);
        check("rst_mid_no_pop_after", {31'd0, obs_rd}, 32'd0);
        @(posedge clk);
        #1;
        run_vec(vecs[10], "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
